// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEF   = 16;
  localparam int RST_DIV_DEF = 2;
  // Widest divisor the helper function accepts; channels zero-extend into it.
  localparam int DIV_W_MAX   = 32;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_t;

  typedef logic [DIV_W_MAX-1:0] div_wide_t;
  typedef logic [DIV_W_MAX:0]   div_hi_t;

  // Length of the high phase: ceil(N/2). One extra bit so N=all-ones cannot wrap.
  function automatic div_hi_t div_hi(input div_wide_t n);
    return (div_hi_t'(n) + div_hi_t'(1)) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: per-channel enables, divisor
// writes, global sync and the divided clock/tick/pending outputs.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DIV_W_DEF
);
  logic [NUM_CH-1:0]       i_en;
  logic [NUM_CH-1:0]       i_div_we;
  logic [NUM_CH*DIV_W-1:0] i_div_wdata;
  logic                    i_sync;
  logic [NUM_CH-1:0]       o_clk;
  logic [NUM_CH-1:0]       o_tick;
  logic [NUM_CH-1:0]       o_pending;

  // Controller side: drives enables/writes/sync, observes clocks.
  modport master (
    output i_en, i_div_we, i_div_wdata, i_sync,
    input  o_clk, o_tick, o_pending
  );

  // Divider side.
  modport slave (
    input  i_en, i_div_we, i_div_wdata, i_sync,
    output o_clk, o_tick, o_pending
  );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/RUN state, period counter, active/shadow
// divisor pair and registered clock/tick outputs. Divisors below 2 pass
// the source clock through a gate enabled by a registered run flag.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int RST_DIV = RST_DIV_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [DIV_W-1:0] i_wdata,
  input  logic             i_sync,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pending
);

  localparam logic [DIV_W-1:0] RST_N = DIV_W'(RST_DIV);
  localparam logic [DIV_W-1:0] N_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] N_TWO = DIV_W'(2);

  div_state_t       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             byp_q, byp_d;

  logic [DIV_W-1:0] n_new;
  logic [DIV_W-1:0] cnt_inc;
  logic             byp_now;
  logic             per_end;
  div_hi_t          hi;

  // Divisor for a period starting on this edge: a same-cycle write beats a pending shadow.
  always_comb begin
    n_new = act_q;
    if (i_we)        n_new = i_wdata;
    else if (pend_q) n_new = shd_q;
  end

  // In bypass every cycle is a period end, so writes there land directly.
  assign byp_now = (act_q < N_TWO);
  assign per_end = byp_now || (cnt_q >= act_q - N_ONE);
  assign cnt_inc = cnt_q + N_ONE;
  assign hi      = div_hi(div_wide_t'(act_q));

  // Next-state: disable > sync/start/period end (all restart at cnt=0) > count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = tick_q;
    if (!i_en) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
      clk_d   = 1'b0;
      tick_d  = 1'b0;
      // Outputs are parked, so a write or a sync-applied shadow can land directly.
      if (i_we || (i_sync && pend_q)) begin
        act_d  = n_new;
        pend_d = 1'b0;
      end
    end else if ((state_q == DIV_IDLE) || i_sync || per_end) begin
      state_d = DIV_RUN;
      cnt_d   = '0;
      act_d   = n_new;
      pend_d  = 1'b0;
      clk_d   = (n_new >= N_TWO);
      tick_d  = (n_new < N_TWO);
    end else begin
      cnt_d  = cnt_inc;
      clk_d  = (div_hi_t'(cnt_inc) < hi);
      tick_d = (cnt_inc == act_q - N_ONE);
      // Mid-period write: hold in shadow until the boundary to avoid a runt.
      if (i_we) begin
        shd_d  = i_wdata;
        pend_d = 1'b1;
      end
    end
  end

  assign byp_d = (state_d == DIV_RUN) && (act_d < N_TWO);

  // State and output registers; reset clears outputs asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      act_q   <= RST_N;
      shd_q   <= RST_N;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      byp_q   <= byp_d;
    end
  end

  // Bypass path is a gated copy of i_clk; time it as a generated clock.
  assign o_clk     = clk_q | (i_clk & byp_q);
  assign o_tick    = tick_q;
  assign o_pending = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent channels,
// shared sync, divisors packed DIV_W bits per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int RST_DIV = RST_DIV_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  clk_div_multi_if.slave bus
);

  logic [NUM_CH-1:0] clk_w;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] pend_w;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_chan #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (bus.i_en[k]),
      .i_we      (bus.i_div_we[k]),
      .i_wdata   (bus.i_div_wdata[k*DIV_W +: DIV_W]),
      .i_sync    (bus.i_sync),
      .o_clk     (clk_w[k]),
      .o_tick    (tick_w[k]),
      .o_pending (pend_w[k])
    );
  end

  assign bus.o_clk     = clk_w;
  assign bus.o_tick    = tick_w;
  assign bus.o_pending = pend_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random traffic, all
// outputs compared every cycle against a period/phase reference model.
module tb_clk_div_multi;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int RSTD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NCH-1:0]    en   = '0;
  logic [NCH-1:0]    we   = '0;
  logic [NCH*DW-1:0] wdat = '0;
  logic              sync = 1'b0;

  clk_div_multi_if #(.NUM_CH(NCH), .DIV_W(DW)) bus();

  assign bus.i_en        = en;
  assign bus.i_div_we    = we;
  assign bus.i_div_wdata = wdat;
  assign bus.i_sync      = sync;

  clk_div_multi #(.NUM_CH(NCH), .DIV_W(DW), .RST_DIV(RSTD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: running flag, position within the current output
  // period, active divisor, shadow divisor and pending flag per channel.
  bit m_run [NCH];
  int m_pos [NCH];
  int m_act [NCH];
  int m_shd [NCH];
  bit m_pend[NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < NCH; k++) begin
      m_run[k] = 0; m_pos[k] = 0; m_act[k] = RSTD; m_shd[k] = RSTD; m_pend[k] = 0;
    end
  endfunction

  // Apply one source-clock edge with the current inputs.
  function automatic void m_edge();
    for (int k = 0; k < NCH; k++) begin
      int wv;
      wv = int'(wdat[k*DW +: DW]);
      if (!en[k]) begin
        m_run[k] = 0; m_pos[k] = 0;
        if (we[k]) begin m_act[k] = wv; m_pend[k] = 0; end
        else if (sync && m_pend[k]) begin m_act[k] = m_shd[k]; m_pend[k] = 0; end
      end else if (!m_run[k] || sync || m_act[k] < 2 || m_pos[k] == m_act[k] - 1) begin
        if (we[k])          m_act[k] = wv;
        else if (m_pend[k]) m_act[k] = m_shd[k];
        m_pend[k] = 0; m_run[k] = 1; m_pos[k] = 0;
      end else begin
        m_pos[k]++;
        if (we[k]) begin m_shd[k] = wv; m_pend[k] = 1; end
      end
    end
  endfunction

  function automatic bit e_clk(int k, bit ic);
    if (!m_run[k])     return 1'b0;
    if (m_act[k] < 2)  return ic;
    return (m_pos[k] < (m_act[k] + 1) / 2);
  endfunction

  function automatic bit e_tick(int k);
    return m_run[k] && (m_act[k] < 2 || m_pos[k] == m_act[k] - 1);
  endfunction

  task automatic check_hi();
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("clk_hi%0d", k), 32'(bus.o_clk[k]),     32'(e_clk(k, 1'b1)));
      chk($sformatf("tick%0d", k),   32'(bus.o_tick[k]),    32'(e_tick(k)));
      chk($sformatf("pend%0d", k),   32'(bus.o_pending[k]), 32'(m_pend[k]));
    end
  endtask

  task automatic check_lo();
    for (int k = 0; k < NCH; k++)
      chk($sformatf("clk_lo%0d", k), 32'(bus.o_clk[k]), 32'(e_clk(k, 1'b0)));
  endtask

  // One source cycle; returns at negedge+1 where the caller sets new inputs.
  task automatic step();
    @(posedge clk);
    if (!rst) m_edge();
    cyc++;
    #1 check_hi();
    @(negedge clk);
    #1 check_lo();
  endtask

  task automatic wr(input int k, input int n);
    we[k] = 1'b1;
    wdat[k*DW +: DW] = DW'(n);
  endtask

  initial begin
    int cnt;
    m_reset();

    // Reset state
    step(); step();
    rst = 1'b0;

    // 1: ch0 N=4 written in IDLE, then enabled -> 1,1,0,0
    wr(0, 4); step(); we = '0;
    en[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(); en[0] = 1'b1;
      chk("t1_clk",  32'(bus.o_clk[0]),  32'((i % 4) < 2));
      chk("t1_tick", 32'(bus.o_tick[0]), 32'((i % 4) == 3));
    end

    // 2: ch1 N=5 written and enabled together -> high 3, low 2
    wr(1, 5); en[1] = 1'b1; step(); we = '0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("t2_clk",  32'(bus.o_clk[1]),  32'((i % 5) < 3));
      chk("t2_tick", 32'(bus.o_tick[1]), 32'((i % 5) == 4));
    end

    // 3: ch0 write 6 at cnt=1 -> pending for 2 cycles, then 3/3
    for (int i = 0; i < 8 && m_pos[0] != 1; i++) step();
    chk("t3_wait", 32'(m_pos[0]), 32'd1);
    wr(0, 6); step(); we = '0;
    cnt = int'(bus.o_pending[0]);
    for (int i = 0; i < 9; i++) begin step(); cnt += int'(bus.o_pending[0]); end
    chk("t3_pend_cycles", 32'(cnt), 32'd2);
    repeat (12) step();

    // 4: ch0 N=4, ch1 N=6 at arbitrary phase, then sync
    wr(0, 4); wr(1, 6); step(); we = '0;
    repeat ($urandom_range(7)) step();
    sync = 1'b1; step(); sync = 1'b0;
    chk("t4_clk0", 32'(bus.o_clk[0]), 32'd1);
    chk("t4_clk1", 32'(bus.o_clk[1]), 32'd1);
    cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (bus.o_tick[0] && bus.o_tick[1]) cnt++;
    end
    chk("t4_coincide", 32'(cnt), 32'd2);

    // 5: bypass N=0 on ch2 and N=1 on ch3, then drop ch2
    wr(2, 0); wr(3, 1); en[2] = 1'b1; en[3] = 1'b1; step(); we = '0;
    repeat (6) step();
    en[2] = 1'b0; step();
    chk("t5_off", 32'(bus.o_clk[2]), 32'd0);
    repeat (3) step();

    // 6: async reset during the high phase of N=8
    wr(2, 8); en[2] = 1'b1; step(); we = '0;
    chk("t6_pre", 32'(bus.o_clk[2]), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_clk",  32'(bus.o_clk),     32'd0);
    chk("t6_tick", 32'(bus.o_tick),    32'd0);
    chk("t6_pend", 32'(bus.o_pending), 32'd0);
    m_reset();
    step(); step();
    rst = 1'b0;
    repeat (8) step();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(99) < 2) en[k] = ~en[k];
        we[k] = ($urandom_range(99) < 10);
        wdat[k*DW +: DW] = DW'(($urandom_range(9) == 0) ? $urandom_range(40) : $urandom_range(9));
      end
      sync = ($urandom_range(99) < 3);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
